// File: rtl/ila_framer_pkg.sv
// Shared types and constants for the ILA stream framer.
// State encoding, header tag default and header field layout.
package ila_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [7:0] MAGIC_DEF = 8'hA5;

  localparam int TAG_MSB  = 31;
  localparam int TAG_LSB  = 24;
  localparam int RSVD_MSB = 23;
  localparam int RSVD_LSB = 16;
  localparam int CNT_MSB  = 15;
  localparam int CNT_LSB  = 0;

  function automatic logic [31:0] make_hdr(
    input logic [7:0]  tag,
    input logic [15:0] cnt
  );
    logic [31:0] h;
    h = '0;
    h[TAG_MSB:TAG_LSB]   = tag;
    h[RSVD_MSB:RSVD_LSB] = 8'h00;
    h[CNT_MSB:CNT_LSB]   = cnt;
    return h;
  endfunction

endpackage

// File: rtl/ila_skid_buf.sv
// Two-entry output buffer carrying {data, tlast}; head drives the port.
// Ports: clk/rst_n, en (cke), clr (soft reset), push/din, rdy, dout/valid, full/empty.
module ila_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         rdy,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic [1:0]   cnt;
  logic         pop;
  logic         psh;

  assign pop   = en & (cnt != 2'd0) & rdy;
  assign psh   = en & push & (cnt != 2'd2);
  assign dout  = ent0;
  assign valid = (cnt != 2'd0);
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

  // ent0 only moves on a pop or on a push into an empty buffer,
  // so the presented word holds while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
    end else if (clr) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
    end else begin
      unique case ({psh, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= din;
          else             ent1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          ent1 <= '0;
          cnt  <= cnt - 2'd1;
        end
        // push+pop only possible with one entry held
        2'b11: ent0 <= din;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ila_stream_framer.sv
// Frames ILA stream words: one header, then n payload words, tlast per burst.
// Ports: clk/reset/cke/soft reset, start+count, ILA slave, DMA master, busy/done.
module ila_stream_framer
  import ila_framer_pkg::*;
#(
  parameter int         DATA_W  = 32,
  parameter int         CNT_W   = 16,
  parameter int         BURST_W = 4,
  parameter logic [7:0] MAGIC   = MAGIC_DEF
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  n_words_i,
  input  logic [DATA_W-1:0] s_tdata_i,
  input  logic              s_tvalid_i,
  output logic              s_tready_o,
  output logic [DATA_W-1:0] m_tdata_o,
  output logic              m_tvalid_o,
  input  logic              m_tready_i,
  output logic              m_tlast_o,
  output logic              busy_o,
  output logic              done_o
);

  state_t             state;
  logic [CNT_W-1:0]   cnt_total;
  logic [CNT_W-1:0]   word_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic               done_q;

  logic               sk_full;
  logic               sk_empty;
  logic               sk_valid;
  logic [DATA_W:0]    sk_dout;
  logic [DATA_W:0]    push_data;
  logic               push;

  logic               s_hs;
  logic               hdr_push;
  logic               last_word;
  logic               pay_last;
  logic [DATA_W-1:0]  hdr;

  // Ready is built from flops only: state and the buffer fill level.
  assign s_tready_o = (state == ST_PAYLOAD) & ~sk_full;
  assign s_hs       = s_tvalid_i & s_tready_o & cke_i;
  assign hdr_push   = (state == ST_HEADER) & ~sk_full & cke_i;
  assign last_word  = (word_cnt == cnt_total - CNT_W'(1));
  assign pay_last   = (&burst_cnt) | last_word;
  assign hdr        = DATA_W'(make_hdr(MAGIC, 16'(cnt_total)));

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (hdr_push) begin
      push      = 1'b1;
      push_data = {hdr, (cnt_total == '0)};
    end else if (s_hs) begin
      push      = 1'b1;
      push_data = {s_tdata_i, pay_last};
    end
  end

  ila_skid_buf #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk   (clk_i),
    .rst_n (arst_n_i),
    .en    (cke_i),
    .clr   (rst_i),
    .push  (push),
    .din   (push_data),
    .rdy   (m_tready_i),
    .dout  (sk_dout),
    .valid (sk_valid),
    .full  (sk_full),
    .empty (sk_empty)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state     <= ST_IDLE;
      cnt_total <= '0;
      word_cnt  <= '0;
      burst_cnt <= '0;
      done_q    <= 1'b0;
    end else if (rst_i) begin
      state     <= ST_IDLE;
      cnt_total <= '0;
      word_cnt  <= '0;
      burst_cnt <= '0;
      done_q    <= 1'b0;
    end else if (cke_i) begin
      unique case (state)
        ST_IDLE: begin
          if (start_i) begin
            cnt_total <= n_words_i;
            word_cnt  <= '0;
            burst_cnt <= '0;
            done_q    <= 1'b0;
            state     <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (!sk_full) begin
            state <= (cnt_total == '0) ? ST_DONE : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (s_hs) begin
            word_cnt  <= word_cnt + CNT_W'(1);
            burst_cnt <= pay_last ? '0 : burst_cnt + BURST_W'(1);
            if (last_word) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (sk_empty) begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_tdata_o  = sk_dout[DATA_W:1];
  assign m_tlast_o  = sk_dout[0];
  assign m_tvalid_o = sk_valid;
  assign busy_o     = (state != ST_IDLE);
  assign done_o     = done_q;

endmodule
